// File: rtl/exist_node_fetch_pkg.sv
// Shared constants for the existential-quantification node fetcher: terminal
// indices, default field widths, the terminal "top" value and the FSM encoding.
package exist_node_fetch_pkg;

  localparam int unsigned INDEX_DEF = 20;
  localparam int unsigned VAR_DEF   = 8;

  localparam int unsigned BDD_ZERO = 0;
  localparam int unsigned BDD_ONE  = 1;

  // Terminals report a top variable of all ones so they sort below every real variable.
  localparam bit TERM_TOP_BIT = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/exist_fetch_cache.sv
// One-entry node cache for exist_node_fetch; only built when EXIST_FETCH_CACHE_EN
// is defined, so the default build carries no cache storage at all.
`ifdef EXIST_FETCH_CACHE_EN
module exist_fetch_cache #(
  parameter int unsigned IndexW = 20,
  parameter int unsigned VarW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              fill_i,
  input  logic [IndexW-1:0] fill_f_i,
  input  logic [VarW-1:0]   fill_var_i,
  input  logic [IndexW-1:0] fill_low_i,
  input  logic [IndexW-1:0] fill_high_i,
  input  logic [IndexW-1:0] lookup_f_i,
  output logic              hit_o,
  output logic [VarW-1:0]   hit_var_o,
  output logic [IndexW-1:0] hit_low_o,
  output logic [IndexW-1:0] hit_high_o
);

  logic              valid_q;
  logic [IndexW-1:0] f_q;
  logic [VarW-1:0]   var_q;
  logic [IndexW-1:0] low_q;
  logic [IndexW-1:0] high_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      f_q     <= '0;
      var_q   <= '0;
      low_q   <= '0;
      high_q  <= '0;
    end else if (flush_i) begin
      // Flush wins over a fill arriving in the same cycle.
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      f_q     <= fill_f_i;
      var_q   <= fill_var_i;
      low_q   <= fill_low_i;
      high_q  <= fill_high_i;
    end
  end

  always_comb begin
    hit_o      = valid_q && (f_q == lookup_f_i);
    hit_var_o  = var_q;
    hit_low_o  = low_q;
    hit_high_o = high_q;
  end

endmodule
`endif

// File: rtl/exist_node_fetch.sv
// Fetches {var, low, high} of one BDD node per request; terminals bypass memory.
// Optional one-entry result cache enabled by defining EXIST_FETCH_CACHE_EN.
module exist_node_fetch
  import exist_node_fetch_pkg::*;
#(
  parameter int unsigned INDEX_W = INDEX_DEF,
  parameter int unsigned VAR_W   = VAR_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
`ifdef EXIST_FETCH_CACHE_EN
  input  logic                       cache_flush,
`endif
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [INDEX_W-1:0]         req_f,
  input  logic [VAR_W-1:0]           req_cube_last_var,
  output logic                       mem_rd_en,
  output logic [INDEX_W-1:0]         mem_rd_addr,
  input  logic                       mem_rd_valid,
  input  logic [VAR_W+2*INDEX_W-1:0] mem_rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INDEX_W-1:0]         out_f,
  output logic [INDEX_W-1:0]         out_low,
  output logic [INDEX_W-1:0]         out_high,
  output logic [VAR_W-1:0]           out_top,
  output logic [VAR_W-1:0]           out_cube_last_var
);

  localparam int unsigned DataW = VAR_W + 2 * INDEX_W;

  fetch_state_e       state_q;
  logic               req_ready_q;
  logic               mem_rd_en_q;
  logic               out_valid_q;
  logic [INDEX_W-1:0] f_q;
  logic [INDEX_W-1:0] low_q;
  logic [INDEX_W-1:0] high_q;
  logic [VAR_W-1:0]   top_q;
  logic [VAR_W-1:0]   cvar_q;

  logic               req_is_term;
  logic               accept;
  logic               capture;
  logic [VAR_W-1:0]   mem_var;
  logic [INDEX_W-1:0] mem_low;
  logic [INDEX_W-1:0] mem_high;

  logic               cache_hit;
  logic [VAR_W-1:0]   cache_var;
  logic [INDEX_W-1:0] cache_low;
  logic [INDEX_W-1:0] cache_high;

  always_comb begin
    req_is_term = (req_f == INDEX_W'(BDD_ZERO)) || (req_f == INDEX_W'(BDD_ONE));
    accept      = (state_q == StIdle) && req_valid && req_ready_q;
    // Read data is only meaningful while a read is outstanding.
    capture     = (state_q == StWait) && mem_rd_valid;
    mem_var     = mem_rd_data[DataW-1 -: VAR_W];
    mem_low     = mem_rd_data[2*INDEX_W-1 -: INDEX_W];
    mem_high    = mem_rd_data[INDEX_W-1:0];
  end

`ifdef EXIST_FETCH_CACHE_EN
  exist_fetch_cache #(
    .IndexW (INDEX_W),
    .VarW   (VAR_W)
  ) u_cache (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .flush_i     (cache_flush),
    .fill_i      (capture),
    .fill_f_i    (f_q),
    .fill_var_i  (mem_var),
    .fill_low_i  (mem_low),
    .fill_high_i (mem_high),
    .lookup_f_i  (req_f),
    .hit_o       (cache_hit),
    .hit_var_o   (cache_var),
    .hit_low_o   (cache_low),
    .hit_high_o  (cache_high)
  );
`else
  always_comb begin
    cache_hit  = 1'b0;
    cache_var  = '0;
    cache_low  = '0;
    cache_high = '0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      low_q       <= '0;
      high_q      <= '0;
      top_q       <= '0;
      cvar_q      <= '0;
    end else begin
      mem_rd_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            f_q         <= req_f;
            cvar_q      <= req_cube_last_var;
            if (req_is_term) begin
              top_q       <= {VAR_W{TERM_TOP_BIT}};
              low_q       <= req_f;
              high_q      <= req_f;
              out_valid_q <= 1'b1;
              state_q     <= StHold;
            end else if (cache_hit) begin
              top_q       <= cache_var;
              low_q       <= cache_low;
              high_q      <= cache_high;
              out_valid_q <= 1'b1;
              state_q     <= StHold;
            end else begin
              // Strobe is registered so it is high for exactly the ISSUE cycle.
              mem_rd_en_q <= 1'b1;
              state_q     <= StIssue;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (capture) begin
            top_q       <= mem_var;
            low_q       <= mem_low;
            high_q      <= mem_high;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    req_ready         = req_ready_q;
    mem_rd_en         = mem_rd_en_q;
    mem_rd_addr       = f_q;
    out_valid         = out_valid_q;
    out_f             = f_q;
    out_low           = low_q;
    out_high          = high_q;
    out_top           = top_q;
    out_cube_last_var = cvar_q;
  end

endmodule

// File: tb/tb_exist_node_fetch.sv
// Directed bench for exist_node_fetch; checks the cached variant when
// EXIST_FETCH_CACHE_EN is defined, the memory-only variant otherwise.
module tb_exist_node_fetch;

  localparam int unsigned IW = 20;
  localparam int unsigned VW = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [IW-1:0]     req_f = '0;
  logic [VW-1:0]     req_cube_last_var = '0;
  logic              mem_rd_en;
  logic [IW-1:0]     mem_rd_addr;
  logic              mem_rd_valid = 1'b0;
  logic [VW+2*IW-1:0] mem_rd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [IW-1:0]     out_f;
  logic [IW-1:0]     out_low;
  logic [IW-1:0]     out_high;
  logic [VW-1:0]     out_top;
  logic [VW-1:0]     out_cube_last_var;
`ifdef EXIST_FETCH_CACHE_EN
  logic              cache_flush = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int rd_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) rd_count <= rd_count + 1;

  exist_node_fetch #(
    .INDEX_W (IW),
    .VAR_W   (VW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
`ifdef EXIST_FETCH_CACHE_EN
    .cache_flush       (cache_flush),
`endif
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_f             (req_f),
    .req_cube_last_var (req_cube_last_var),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_valid      (mem_rd_valid),
    .mem_rd_data       (mem_rd_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_f             (out_f),
    .out_low           (out_low),
    .out_high          (out_high),
    .out_top           (out_top),
    .out_cube_last_var (out_cube_last_var)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; memory answers mem_lat cycles after the strobe cycle.
  // lat = cycles from the accept cycle to the first cycle out_valid is seen.
  task automatic fetch(input logic [IW-1:0] f, input logic [VW-1:0] cv, input int mem_lat,
                       input logic [VW+2*IW-1:0] rdata, output int lat, output int issue_cyc,
                       output logic [IW-1:0] addr);
    lat = 0;
    issue_cyc = 0;
    addr = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_f = f;
    req_cube_last_var = cv;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_rd_valid = 1'b0;
      if (out_valid) begin
        lat = cyc;
        break;
      end
      if (mem_rd_en) begin
        issue_cyc = cyc;
        addr = mem_rd_addr;
      end
      if (issue_cyc != 0 && cyc == issue_cyc + mem_lat) begin
        mem_rd_valid = 1'b1;
        mem_rd_data = rdata;
      end
    end
  endtask

  int lat;
  int iss;
  logic [IW-1:0] addr;
  int exp_lat2;
  int exp_rd2;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_out_top", 64'(out_top), 64'd0);
    check("rst_out_f", 64'(out_f), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Terminal zero
    fetch(20'h0, 8'h11, 3, '0, lat, iss, addr);
    check("t0_latency", 64'(lat), 64'd1);
    check("t0_no_read", 64'(iss), 64'd0);
    check("t0_top", 64'(out_top), 64'hFF);
    check("t0_low", 64'(out_low), 64'h0);
    check("t0_high", 64'(out_high), 64'h0);
    check("t0_cvar", 64'(out_cube_last_var), 64'h11);
    check("t0_req_ready_busy", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t0_back_idle", 64'(req_ready), 64'd1);
    check("t0_valid_drop", 64'(out_valid), 64'd0);

    // Terminal one
    fetch(20'h1, 8'h07, 3, '0, lat, iss, addr);
    check("t1_latency", 64'(lat), 64'd1);
    check("t1_f", 64'(out_f), 64'h1);
    check("t1_cvar", 64'(out_cube_last_var), 64'h07);
    check("t1_top", 64'(out_top), 64'hFF);
    check("t1_low_high", 64'({out_low, out_high}), 64'({20'h1, 20'h1}));
    check("t1_rd_count", 64'(rd_count), 64'd0);
    @(negedge clk);

    // Non-terminal, memory latency 3, then held in HOLD
    out_ready = 1'b0;
    fetch(20'h123, 8'h22, 3, {8'h05, 20'h40, 20'h41}, lat, iss, addr);
    check("nt_issue_cycle", 64'(iss), 64'd1);
    check("nt_addr", 64'(addr), 64'h123);
    check("nt_latency", 64'(lat), 64'd5);
    check("nt_top", 64'(out_top), 64'h05);
    check("nt_low", 64'(out_low), 64'h40);
    check("nt_high", 64'(out_high), 64'h41);
    check("nt_f", 64'(out_f), 64'h123);
    check("nt_rd_count", 64'(rd_count), 64'd1);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_f = 20'h0;
      mem_rd_valid = 1'b1;
      mem_rd_data = {8'hAA, 20'hBBBBB, 20'hCCCCC};
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_data", 64'({out_top, out_low, out_high}), 64'({8'h05, 20'h40, 20'h41}));
      check("hold_f", 64'(out_f), 64'h123);
    end
    req_valid = 1'b0;
    mem_rd_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("no_stray_accept", 64'(out_valid), 64'd0);
    check("no_stray_read", 64'(rd_count), 64'd1);

    // Repeat of the same node: cache hit when built in, else another read
`ifdef EXIST_FETCH_CACHE_EN
    exp_lat2 = 1;
    exp_rd2 = 1;
`else
    exp_lat2 = 5;
    exp_rd2 = 2;
`endif
    fetch(20'h123, 8'h33, 3, {8'h05, 20'h40, 20'h41}, lat, iss, addr);
    check("rep_latency", 64'(lat), 64'(exp_lat2));
    check("rep_rd_count", 64'(rd_count), 64'(exp_rd2));
    check("rep_data", 64'({out_top, out_low, out_high}), 64'({8'h05, 20'h40, 20'h41}));
    check("rep_cvar", 64'(out_cube_last_var), 64'h33);
    @(negedge clk);
`ifdef EXIST_FETCH_CACHE_EN
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
`endif
    fetch(20'h123, 8'h44, 3, {8'h06, 20'h50, 20'h51}, lat, iss, addr);
    check("flush_latency", 64'(lat), 64'd5);
    check("flush_rd_count", 64'(rd_count), 64'(exp_rd2 + 1));
    check("flush_data", 64'({out_top, out_low, out_high}), 64'({8'h06, 20'h50, 20'h51}));
    @(negedge clk);

    // Reset pulsed while waiting on memory; the late response must be dropped
    @(negedge clk);
    req_valid = 1'b1;
    req_f = 20'h55;
    req_cube_last_var = 8'h09;
    @(negedge clk);
    req_valid = 1'b0;
    check("rw_strobe", 64'(mem_rd_en), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rw_rst_out_valid", 64'(out_valid), 64'd0);
    check("rw_rst_req_ready", 64'(req_ready), 64'd0);
    check("rw_rst_out_f", 64'(out_f), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rw_idle_ready", 64'(req_ready), 64'd1);
    mem_rd_valid = 1'b1;
    mem_rd_data = {8'h0A, 20'h60, 20'h61};
    @(negedge clk);
    mem_rd_valid = 1'b0;
    check("rw_late_valid", 64'(out_valid), 64'd0);
    check("rw_late_top", 64'(out_top), 64'd0);
    @(negedge clk);
    check("rw_late_valid2", 64'(out_valid), 64'd0);
    fetch(20'h0, 8'h01, 3, '0, lat, iss, addr);
    check("rw_recover_latency", 64'(lat), 64'd1);
    check("rw_recover_top", 64'(out_top), 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exist_node_fetch.md
EXIST_NODE_FETCH -- requirements
Module: exist_node_fetch

Interface
REQ-001 SHALL have parameter INDEX_W, default 20: width of a node index.
REQ-002 SHALL have parameter VAR_W, default 8: width of a variable number.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `reset_n` (in, 1, reset); one clock, asynchronous active-low reset.
REQ-004 SHALL have port req_valid (in, 1): request present.
REQ-005 SHALL have port req_ready (out, 1): request accepted this cycle when both are high.
REQ-006 SHALL have port req_f (in, INDEX_W): node index to fetch.
REQ-007 SHALL have port req_cube_last_var (in, VAR_W): passed through to the output.
REQ-008 SHALL have port mem_rd_en (out, 1): one-cycle read strobe.
REQ-009 SHALL have port mem_rd_addr (out, INDEX_W): node index read.
REQ-010 SHALL have port mem_rd_valid (in, 1): read data valid, any latency >=1.
REQ-011 SHALL have port mem_rd_data (in, VAR_W+2*INDEX_W): {var, low, high}, MSB first.
REQ-012 SHALL have ports out_valid (out, 1) and out_ready (in, 1): output handshake.
REQ-013 SHALL have ports out_f, out_low, out_high (out, INDEX_W each) and out_top, out_cube_last_var (out, VAR_W each).
REQ-014 SHALL have port cache_flush (in, 1), present only with EXIST_FETCH_CACHE_EN.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, HOLD.
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 On accept of a terminal f (0 = BDD_ZERO, 1 = BDD_ONE), SHALL go to HOLD next cycle with no memory read: out_top = all ones, out_low = out_high = f.
REQ-018 On accept of a non-terminal f, SHALL latch f and cube var and go to ISSUE.
REQ-019 In ISSUE, SHALL assert mem_rd_en for exactly one cycle with mem_rd_addr = latched f, then go to WAIT.
REQ-020 In WAIT, on mem_rd_valid SHALL capture var/low/high into out_top/out_low/out_high and go to HOLD.
REQ-021 SHALL ignore mem_rd_valid in any state other than WAIT.
REQ-022 In HOLD, SHALL assert out_valid with all outputs stable until out_ready; on out_ready SHALL return to IDLE.
REQ-023 With out_ready already high, terminal latency SHALL be accept-to-out_valid = 1 cycle; non-terminal latency SHALL be 2 + memory latency cycles.
REQ-024 The block SHALL hold at most one request in flight; throughput is one request per (latency + 1) cycles.
REQ-025 out_f and out_cube_last_var SHALL equal the accepted req_f and req_cube_last_var.

Reset
REQ-026 reset_n low SHALL force IDLE asynchronously, with req_ready=0 during reset and 1 at the first clock after release, mem_rd_en=0, out_valid=0, and all data outputs 0.
REQ-027 Reset during WAIT SHALL abandon the read; a late mem_rd_valid after reset SHALL be ignored (REQ-021).

Configuration
REQ-028 With macro EXIST_FETCH_CACHE_EN defined, SHALL keep a one-entry cache {valid, f, var, low, high} filled on every REQ-020 capture.
REQ-029 With EXIST_FETCH_CACHE_EN, a non-terminal request matching a valid cache entry SHALL skip ISSUE/WAIT and enter HOLD next cycle with cached data.
REQ-030 With EXIST_FETCH_CACHE_EN, cache valid SHALL clear on reset and on cache_flush (flush priority over fill in the same cycle).
REQ-031 Without EXIST_FETCH_CACHE_EN, every non-terminal request SHALL read memory, and neither cache_flush nor cache storage SHALL exist.

Structure
REQ-032 BDD_ZERO, BDD_ONE, INDEX_DEF/VAR_DEF widths, the terminal-top value and the state encoding SHALL live in the shared constants file.
REQ-033 The cache SHALL be a sub-module exist_fetch_cache; everything else SHALL be flat.

Verification
REQ-034 Directed test: req f=0 -> out_valid 1 cycle later, out_top=0xFF, low=high=0, no mem_rd_en.
REQ-035 Directed test: req f=0x123, mem latency 3 returning {0x05,0x40,0x41} -> mem_rd_addr=0x123, out_valid 5 cycles after accept, top=5, low=0x40, high=0x41.
REQ-036 Directed test: out_ready held low 10 cycles in HOLD -> outputs stable, req_ready=0 throughout, new req_valid not accepted.
REQ-037 Directed test: reset_n pulsed in WAIT, then mem_rd_valid arrives -> state IDLE, out_valid stays 0.
REQ-038 Directed test (cache build): two consecutive reqs f=0x123 -> one mem read only; with cache_flush between them -> two reads.
REQ-039 Directed test: req f=1 with cube_last_var=0x07 -> out_f=1, out_cube_last_var=0x07, out_top=0xFF.
